// File: rtl/bcd_pkg.sv
// Shared BCD digit type, bounds and per-digit helpers for the BCD counter.
// bcd_next gives the next digit value for one increment or decrement step.
package bcd_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;
   localparam bcd_t BCD_MIN = 4'd0;

   function automatic logic is_bcd(input bcd_t digit);
      return (digit <= BCD_MAX);
   endfunction

   // Codes A-F are treated as out of range: up gives 0, down gives 9.
   function automatic bcd_t bcd_next(input bcd_t digit, input logic up);
      bcd_t r;
      if (up) begin
         if (digit >= BCD_MAX) r = BCD_MIN;
         else                  r = digit + 4'd1;
      end else begin
         if ((digit == BCD_MIN) || !is_bcd(digit)) r = BCD_MAX;
         else                                      r = digit - 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit with parallel load and a single-step enable.
// is_nine / is_zero reflect the current digit and feed the top's step chain.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   input  bcd_t load_d,
   input  logic step,
   input  logic up,
   output bcd_t q,
   output logic is_nine,
   output logic is_zero
);

   bcd_t q_r;

   // Digit register: load wins over step, otherwise hold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_r <= BCD_MIN;
      end else if (load) begin
         q_r <= load_d;
      end else if (step) begin
         q_r <= bcd_next(q_r, up);
      end else begin
         q_r <= q_r;
      end
   end

   assign q       = q_r;
   assign is_nine = (q_r == BCD_MAX);
   assign is_zero = (q_r == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Synchronous N-digit BCD up/down counter with load, wrap/saturate mode and
// registered carry, terminal-count and load-error flags.
module bcd_updown_counter
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2,
   parameter int WRAP   = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                en,
   input  logic                up,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   output logic [4*DIGITS-1:0] count,
   output logic                carry,
   output logic                at_max,
   output logic                at_zero,
   output logic                load_err
);

   localparam int   W       = 4 * DIGITS;
   localparam logic WRAP_EN = (WRAP != 0);

   logic [DIGITS-1:0] nine_s;
   logic [DIGITS-1:0] zero_s;
   logic [DIGITS-1:0] valid_s;
   logic [DIGITS-1:0] step_s;
   logic [DIGITS:0]   chain_s;
   logic [W-1:0]      count_s;
   logic [W-1:0]      next_count_s;
   logic              load_ok_s;
   logic              count_en_s;
   logic              at_bound_s;
   logic              next_max_s;
   logic              next_zero_s;

   logic carry_r;
   logic at_max_r;
   logic at_zero_r;
   logic load_err_r;

   // chain_s[i]: every digit below i is at its turnover value for this direction.
   assign chain_s[0]  = 1'b1;
   assign at_bound_s  = chain_s[DIGITS];
   assign load_ok_s   = load & (&valid_s);
   assign count_en_s  = ~load & en & (WRAP_EN | ~at_bound_s);

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign valid_s[i]     = is_bcd(load_val[4*i +: 4]);
      assign chain_s[i+1]   = chain_s[i] & (up ? nine_s[i] : zero_s[i]);
      assign step_s[i]      = count_en_s & chain_s[i];
      assign next_count_s[4*i +: 4] = load_ok_s ? load_val[4*i +: 4] :
                                      step_s[i] ? bcd_next(count_s[4*i +: 4], up) :
                                                  count_s[4*i +: 4];

      bcd_digit u_digit (
         .clk     (clk),
         .reset_n (reset_n),
         .load    (load_ok_s),
         .load_d  (load_val[4*i +: 4]),
         .step    (step_s[i]),
         .up      (up),
         .q       (count_s[4*i +: 4]),
         .is_nine (nine_s[i]),
         .is_zero (zero_s[i])
      );
   end

   // Terminal-count flags from the next count so they line up with count.
   always_comb begin
      next_max_s  = 1'b1;
      next_zero_s = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         next_max_s  = next_max_s  & (next_count_s[4*i +: 4] == BCD_MAX);
         next_zero_s = next_zero_s & (next_count_s[4*i +: 4] == BCD_MIN);
      end
   end

   // Flag registers; carry only fires when a wrap is actually taken.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         carry_r    <= 1'b0;
         at_max_r   <= 1'b0;
         at_zero_r  <= 1'b1;
         load_err_r <= 1'b0;
      end else begin
         carry_r    <= count_en_s & at_bound_s;
         at_max_r   <= next_max_s;
         at_zero_r  <= next_zero_s;
         load_err_r <= load & ~(&valid_s);
      end
   end

   assign count    = count_s;
   assign carry    = carry_r;
   assign at_max   = at_max_r;
   assign at_zero  = at_zero_r;
   assign load_err = load_err_r;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter: three instances (2-digit wrap,
// 2-digit saturate, 4-digit wrap) checked against a decimal reference model.
module tb_bcd_updown_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a;
   logic        rst4;
   logic        ld   [3];
   logic        en_a [3];
   logic        up_a [3];
   logic [15:0] lv   [3];
   logic [7:0]  c0, c1;
   logic [15:0] c2;
   logic [2:0]  cy, am, az, le;

   int DG [3] = '{2, 2, 4};
   int WR [3] = '{1, 0, 1};
   int mv [3];
   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] exp_q [$];

   bcd_updown_counter #(.DIGITS(2), .WRAP(1)) dut0 (
      .clk(clk), .reset_n(rst_a), .en(en_a[0]), .up(up_a[0]), .load(ld[0]),
      .load_val(lv[0][7:0]), .count(c0), .carry(cy[0]), .at_max(am[0]),
      .at_zero(az[0]), .load_err(le[0]));

   bcd_updown_counter #(.DIGITS(2), .WRAP(0)) dut1 (
      .clk(clk), .reset_n(rst_a), .en(en_a[1]), .up(up_a[1]), .load(ld[1]),
      .load_val(lv[1][7:0]), .count(c1), .carry(cy[1]), .at_max(am[1]),
      .at_zero(az[1]), .load_err(le[1]));

   bcd_updown_counter #(.DIGITS(4), .WRAP(1)) dut2 (
      .clk(clk), .reset_n(rst4), .en(en_a[2]), .up(up_a[2]), .load(ld[2]),
      .load_val(lv[2]), .count(c2), .carry(cy[2]), .at_max(am[2]),
      .at_zero(az[2]), .load_err(le[2]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (count,carry,at_max,at_zero,load_err)",
                    tag, obs, exp);
   endtask

   function automatic logic [31:0] observe(input int d);
      case (d)
         0:       return {12'b0, 8'b0, c0, cy[0], am[0], az[0], le[0]};
         1:       return {12'b0, 8'b0, c1, cy[1], am[1], az[1], le[1]};
         default: return {12'b0, c2, cy[2], am[2], az[2], le[2]};
      endcase
   endfunction

   function automatic logic [15:0] to_bcd(input int x);
      logic [15:0] r = 16'h0;
      int v = x;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Decimal reference: advances mv[d] and returns the expected output vector.
   function automatic logic [31:0] model(input int d, input logic l, input logic [15:0] v,
                                         input logic e, input logic u);
      int   mx = 1;
      int   ival = 0;
      int   scale = 1;
      logic ok = 1'b1;
      logic c = 1'b0;
      logic lerr = 1'b0;
      for (int i = 0; i < DG[d]; i++) mx = mx * 10;
      mx = mx - 1;
      for (int i = 0; i < DG[d]; i++) begin
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
         ival = ival + int'(v[4*i +: 4]) * scale;
         scale = scale * 10;
      end
      if (l) begin
         if (ok) mv[d] = ival;
         else    lerr = 1'b1;
      end else if (e && u) begin
         if (mv[d] == mx) begin
            if (WR[d] != 0) begin mv[d] = 0; c = 1'b1; end
         end else mv[d] = mv[d] + 1;
      end else if (e) begin
         if (mv[d] == 0) begin
            if (WR[d] != 0) begin mv[d] = mx; c = 1'b1; end
         end else mv[d] = mv[d] - 1;
      end
      return {12'b0, to_bcd(mv[d]), c, (mv[d] == mx), (mv[d] == 0), lerr};
   endfunction

   task automatic step(input int d, input logic l, input logic [15:0] v,
                       input logic e, input logic u);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin ld[k] = 1'b0; en_a[k] = 1'b0; end
      ld[d] = l; lv[d] = v; en_a[d] = e; up_a[d] = u;
      exp_q.push_back(model(d, l, v, e, u));
      @(posedge clk);
      #1;
      check($sformatf("dut%0d_step", d), observe(d), exp_q.pop_front());
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         ld[k] = 1'b0; en_a[k] = 1'b0; up_a[k] = 1'b0; lv[k] = 16'h0; mv[k] = 0;
      end
      rst_a = 1'b0;
      rst4  = 1'b0;
      #12;
      for (int k = 0; k < 3; k++) check($sformatf("reset%0d", k), observe(k), 32'h2);
      @(negedge clk);
      rst_a = 1'b1;
      rst4  = 1'b1;

      // Full up-count with wrap.
      for (int i = 0; i < 100; i++) step(0, 1'b0, 16'h0, 1'b1, 1'b1);
      // Load 10 then count down through zero to 99.
      step(0, 1'b1, 16'h0010, 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) step(0, 1'b0, 16'h0, 1'b1, 1'b0);
      // Rejected load, then legal load.
      step(0, 1'b1, 16'h0042, 1'b0, 1'b0);
      step(0, 1'b1, 16'h003A, 1'b0, 1'b0);
      step(0, 1'b1, 16'h0037, 1'b0, 1'b0);
      // Load beats enable, then hold.
      step(0, 1'b1, 16'h0055, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(0, 1'b0, 16'h0, 1'b0, 1'b1);

      // Saturating instance.
      step(1, 1'b1, 16'h0098, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1, 1'b0, 16'h0, 1'b1, 1'b1);
      step(1, 1'b0, 16'h0, 1'b1, 1'b0);
      step(1, 1'b1, 16'h0000, 1'b0, 1'b0);
      step(1, 1'b0, 16'h0, 1'b1, 1'b0);

      // Four-digit chain, then asynchronous reset mid-count.
      step(2, 1'b1, 16'h0999, 1'b0, 1'b1);
      step(2, 1'b0, 16'h0, 1'b1, 1'b1);
      step(2, 1'b0, 16'h0, 1'b1, 1'b0);
      @(negedge clk);
      en_a[2] = 1'b1;
      up_a[2] = 1'b1;
      rst4    = 1'b0;
      #1;
      mv[2] = 0;
      check("async_reset", observe(2), 32'h2);
      en_a[2] = 1'b0;
      @(negedge clk);
      rst4 = 1'b1;
      step(2, 1'b0, 16'h0, 1'b1, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Synchronous, parametrised N-digit BCD up/down counter for the display and timer path.
- All digits share one clock; there is no ripple clocking and no gated digit clocks.
- Adds parallel load, count enable, direction select, wrap/saturate mode and registered terminal-count flags, which the fixed 2-digit up-only decade counter lacks.
- Drives the 7-segment decoders and the timer control FSM.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); count width is 4*DIGITS.
- WRAP, 1, 1 = roll over at 0/max; 0 = saturate at 0/max.

Ports:
- clk  input  1  system clock, rising-edge active
- reset_n  input  1  asynchronous, active-low reset
- en  input  1  count enable, sampled on rising clk
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load strobe
- load_val  input  4*DIGITS  BCD value to load; digit i is bits [4i+3:4i]
- count  output  4*DIGITS  registered BCD count; digit 0 is least significant
- carry  output  1  registered one-cycle pulse on wrap (up: max->0; down: 0->max)
- at_max  output  1  registered; high while count == all nines
- at_zero  output  1  registered; high while count == 0
- load_err  output  1  registered one-cycle pulse when a load is rejected

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: count = 0, carry = 0, at_max = 0, at_zero = 1, load_err = 0. These apply immediately on reset_n low and hold until the first clk edge after release.
- Priority on each rising clk: load > en > hold.
- Load:
  - When load=1, each digit of load_val is checked.
  - All digits <= 9: count <= load_val, load_err <= 0.
  - Any digit > 9: count is unchanged and load_err <= 1 for one cycle.
  - carry <= 0 on any load cycle.
- Count with en=1, load=0, up=1:
  - Digit 0 increments.
  - Digit i increments when every lower digit is 9; that digit then becomes 0.
  - Fully combinational carry chain, single-cycle update, no ripple delay.
- Count with en=1, load=0, up=0:
  - Digit 0 decrements.
  - Digit i decrements when every lower digit is 0; that digit then becomes 9.
- Upper boundary (count == all nines), up=1, en=1:
  - WRAP=1: count <= 0, carry <= 1.
  - WRAP=0: count holds, carry <= 0.
- Lower boundary (count == 0), up=0, en=1:
  - WRAP=1: count <= all nines, carry <= 1.
  - WRAP=0: count holds, carry <= 0.
- carry is asserted in the same cycle the wrapped count value appears. It is 0 in every other cycle, including hold cycles.
- at_max and at_zero are computed from the next-state value and registered, so they are exactly coincident with count. No combinational path from inputs to outputs.
- Latency: 1 clk from any input to count and to every flag.
- Direction change between cycles needs no dead cycle; up is sampled per edge.
- Reset mid-operation forces all outputs to reset values asynchronously. It also cancels any load or carry pulse in progress.
- Illegal internal digit codes (A-F) are unreachable. If one appears through X/force, the next increment yields 0 and the next decrement yields 9 for that digit.

Decomposition:
- Shared package bcd_pkg holds:
  - BCD_MAX = 4'd9 and BCD_MIN = 4'd0
  - a function is_bcd(digit) returning digit <= 9
  - a typedef for one 4-bit BCD digit
- One sub-module, bcd_digit: a single registered digit.
  - Inputs: clk, reset_n, load, load_d, step, up.
  - Outputs: q, is_nine, is_zero.
  - The top generates DIGITS instances and builds the step enables as prefix-AND of lower is_nine (up) or is_zero (down).
- Boundary, carry, flag and load_err logic lives in the top.

Test Plan:
- Reset then count up: DIGITS=2, WRAP=1, reset_n 0->1, en=1, up=1 for 100 clks -> count steps 00,01..09,10..99 then 00. carry pulses exactly once, in the cycle count=00. at_max is high only while count=99.
- Down-count from load: load_val=8'h10, load=1 for 1 clk, then en=1, up=0 -> count 10,09,08..00,99. carry high only with 99. at_zero high only with 00.
- Saturate: WRAP=0, load 8'h98, en=1, up=1 for 5 clks -> 99 held, carry never asserts, at_max stays 1. Then up=0 for 1 clk -> 98.
- Illegal load: count=8'h42, load_val=8'h3A, load=1 -> count stays 42, load_err=1 for one cycle. Load 8'h37 -> count=37, load_err=0.
- Priority and hold: load=1, en=1, load_val=8'h55 -> count=55, no increment. Then en=0 for 3 clks -> 55 held, carry 0.
- Async reset mid-count: DIGITS=4, count=16'h0999, en=1, up=1; drop reset_n between edges -> count=0000, at_zero=1 immediately. After release plus 1 clk with en=1 -> 0001.
